cw305_ascon_dout_capture: RTL and testbench

//  Downstream consumer of the ASCON bridge output stream (waddr/val_dout/dout/busy), in the crypto clock domain.

---
 rtl/cw305_ascon_dout_capture.sv | 112 +++++++++++
 tb/tb_cw305_ascon_dout_capture.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cw305_ascon_dout_capture.sv
// Captures ASCON bridge result words into an indexed buffer and tracks arrival,
// completion and busy-cycle count for host readback.
module cw305_ascon_dout_capture #(
    parameter int pWORDS  = 8,
    parameter int pADDR_W = 8,
    parameter int pDATA_W = 32
) (
    input  logic                      crypto_clk,
    input  logic                      reset_i,
    input  logic                      I_clear,
    input  logic                      I_busy,
    input  logic                      I_val_dout,
    input  logic [pADDR_W-1:0]        I_waddr,
    input  logic [pDATA_W-1:0]        I_dout,
    input  logic [$clog2(pWORDS)-1:0] I_rd_idx,
    output logic [pDATA_W-1:0]        O_rd_word,
    output logic [pWORDS-1:0]         O_valid_mask,
    output logic [$clog2(pWORDS):0]   O_word_cnt,
    output logic                      O_done,
    output logic                      O_overflow,
    output logic [15:0]               O_cycle_cnt,
    output logic [1:0]                O_fsm_state
);

    localparam int IDX_W = $clog2(pWORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                 busy_q;
    logic                 seen_busy;
    logic [pDATA_W-1:0]   buffer [pWORDS];
    logic                 in_range;
    logic [IDX_W-1:0]     wr_idx;
    logic                 busy_fall;

    // I_val_dout is a one-cycle valid strobe with no ready: the word is consumed
    // in the cycle it is presented or lost; there is no backpressure.
    assign in_range  = ({1'b0, I_waddr} < (pADDR_W + 1)'(pWORDS));
    assign wr_idx    = I_waddr[IDX_W-1:0];
    assign busy_fall = busy_q && !I_busy && seen_busy;

    always_ff @(posedge crypto_clk) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (I_clear) begin
            state_d = RUN;
        end else if (state_q == RUN && busy_fall) begin
            state_d = DONE;
        end
    end

    assign O_done      = (state_q == DONE);
    assign O_fsm_state = state_q;

    always_ff @(posedge crypto_clk) begin
        if (reset_i) begin
            busy_q       <= 1'b0;
            seen_busy    <= 1'b0;
            O_valid_mask <= '0;
            O_word_cnt   <= '0;
            O_overflow   <= 1'b0;
            O_cycle_cnt  <= '0;
            O_rd_word    <= '0;
            for (int i = 0; i < pWORDS; i++) begin
                buffer[i] <= '0;
            end
        end else begin
            busy_q    <= I_busy;
            O_rd_word <= buffer[I_rd_idx];
            // Clear outranks a coincident strobe; buffer data is kept on purpose.
            if (I_clear) begin
                O_valid_mask <= '0;
                O_word_cnt   <= '0;
                O_overflow   <= 1'b0;
                O_cycle_cnt  <= '0;
                seen_busy    <= 1'b0;
            end else if (state_q == RUN) begin
                if (I_busy) begin
                    seen_busy <= 1'b1;
                    if (O_cycle_cnt != 16'hFFFF) begin
                        O_cycle_cnt <= O_cycle_cnt + 16'd1;
                    end
                end
                if (I_val_dout) begin
                    if (in_range) begin
                        buffer[wr_idx] <= I_dout;
                        if (!O_valid_mask[wr_idx]) begin
                            O_valid_mask[wr_idx] <= 1'b1;
                            O_word_cnt           <= O_word_cnt + 1'b1;
                        end
                    end else begin
                        O_overflow <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cw305_ascon_dout_capture.sv
// Directed bench for cw305_ascon_dout_capture: a vector table for the main
// capture/readback flow plus hand-written saturation and reset sequences.
module tb_cw305_ascon_dout_capture;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        clear;
    logic        busy;
    logic        val;
    logic [7:0]  waddr;
    logic [31:0] dout;
    logic [2:0]  rd_idx;
    logic [31:0] rd_word;
    logic [7:0]  mask;
    logic [3:0]  cnt;
    logic        done;
    logic        ovf;
    logic [15:0] cyc;
    logic [1:0]  fsm_state;

    int n_cmp = 0;
    int n_err = 0;

    cw305_ascon_dout_capture dut (
        .crypto_clk   (clk),
        .reset_i      (reset_i),
        .I_clear      (clear),
        .I_busy       (busy),
        .I_val_dout   (val),
        .I_waddr      (waddr),
        .I_dout       (dout),
        .I_rd_idx     (rd_idx),
        .O_rd_word    (rd_word),
        .O_valid_mask (mask),
        .O_word_cnt   (cnt),
        .O_done       (done),
        .O_overflow   (ovf),
        .O_cycle_cnt  (cyc),
        .O_fsm_state  (fsm_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clear;
        logic        busy;
        logic        val;
        logic [7:0]  waddr;
        logic [31:0] dout;
        logic [2:0]  rd_idx;
        logic [7:0]  mask;
        logic [3:0]  cnt;
        logic        done;
        logic        ovf;
        logic [15:0] cyc;
        logic [31:0] rd;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic c, input logic b, input logic v, input logic [7:0] a,
                       input logic [31:0] d, input logic [2:0] r, input logic [7:0] m,
                       input logic [3:0] n, input logic dn, input logic o,
                       input logic [15:0] cy, input logic [31:0] rw);
        vec_t t;
        t.clear = c; t.busy = b; t.val = v; t.waddr = a; t.dout = d; t.rd_idx = r;
        t.mask = m; t.cnt = n; t.done = dn; t.ovf = o; t.cyc = cy; t.rd = rw;
        vq.push_back(t);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] m, input logic [3:0] n,
                           input logic dn, input logic o, input logic [15:0] cy,
                           input logic [31:0] rw);
        chk({tag, ".mask"}, 32'(mask), 32'(m));
        chk({tag, ".cnt"},  32'(cnt),  32'(n));
        chk({tag, ".done"}, 32'(done), 32'(dn));
        chk({tag, ".ovf"},  32'(ovf),  32'(o));
        chk({tag, ".cyc"},  32'(cyc),  32'(cy));
        chk({tag, ".rd"},   rd_word,   rw);
    endtask

    task automatic idle_inputs();
        clear = 1'b0; busy = 1'b0; val = 1'b0; waddr = '0; dout = '0; rd_idx = '0;
    endtask

    initial begin
        reset_i = 1'b1;
        idle_inputs();

        // Reset state and zeroed buffer.
        step();
        step();
        chk_all("reset", 8'h00, 4'd0, 1'b0, 1'b0, 16'd0, 32'd0);
        chk("reset.state", 32'(fsm_state), 32'd0);
        reset_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_idx = 3'(i);
            step();
            chk($sformatf("reset.rd%0d", i), rd_word, 32'd0);
        end

        // Vector table: capture, rewrite, overflow, clear-vs-strobe, coincident completion.
        add(1,0,0,8'd0,32'h0,3'd0, 8'h00,4'd0,0,0,16'd0,32'h0);
        add(0,1,0,8'd0,32'h0,3'd0, 8'h00,4'd0,0,0,16'd1,32'h0);
        add(0,1,1,8'd0,32'hA0,3'd0, 8'h01,4'd1,0,0,16'd2,32'h0);
        add(0,1,1,8'd1,32'hA1,3'd0, 8'h03,4'd2,0,0,16'd3,32'hA0);
        add(0,1,1,8'd2,32'hA2,3'd0, 8'h07,4'd3,0,0,16'd4,32'hA0);
        add(0,1,1,8'd3,32'hA3,3'd0, 8'h0F,4'd4,0,0,16'd5,32'hA0);
        for (int k = 6; k <= 10; k++) begin
            add(0,1,0,8'd0,32'h0,3'd0, 8'h0F,4'd4,0,0,16'(k),32'hA0);
        end
        add(0,0,0,8'd0,32'h0,3'd2, 8'h0F,4'd4,1,0,16'd10,32'hA2);
        add(0,1,1,8'd5,32'h55,3'd5, 8'h0F,4'd4,1,0,16'd10,32'h0);
        add(0,0,0,8'd0,32'h0,3'd5, 8'h0F,4'd4,1,0,16'd10,32'h0);
        add(1,0,0,8'd0,32'h0,3'd2, 8'h00,4'd0,0,0,16'd0,32'hA2);
        add(0,0,1,8'd1,32'h11,3'd1, 8'h02,4'd1,0,0,16'd0,32'hA1);
        add(0,0,1,8'd1,32'h22,3'd1, 8'h02,4'd1,0,0,16'd0,32'h11);
        add(0,0,0,8'd0,32'h0,3'd1, 8'h02,4'd1,0,0,16'd0,32'h22);
        add(0,0,1,8'd9,32'h99,3'd1, 8'h02,4'd1,0,1,16'd0,32'h22);
        add(0,0,1,8'd8,32'h88,3'd0, 8'h02,4'd1,0,1,16'd0,32'hA0);
        add(0,0,0,8'd0,32'h0,3'd0, 8'h02,4'd1,0,1,16'd0,32'hA0);
        add(1,0,1,8'd0,32'hDEAD,3'd0, 8'h00,4'd0,0,0,16'd0,32'hA0);
        add(0,0,0,8'd0,32'h0,3'd0, 8'h00,4'd0,0,0,16'd0,32'hA0);
        add(1,0,0,8'd0,32'h0,3'd0, 8'h00,4'd0,0,0,16'd0,32'hA0);
        add(0,1,0,8'd0,32'h0,3'd0, 8'h00,4'd0,0,0,16'd1,32'hA0);
        add(0,0,1,8'd7,32'h77,3'd7, 8'h80,4'd1,1,0,16'd1,32'h0);
        add(0,0,0,8'd0,32'h0,3'd7, 8'h80,4'd1,1,0,16'd1,32'h77);

        foreach (vq[i]) begin
            clear = vq[i].clear; busy = vq[i].busy; val = vq[i].val;
            waddr = vq[i].waddr; dout = vq[i].dout; rd_idx = vq[i].rd_idx;
            step();
            chk_all($sformatf("vec%0d", i), vq[i].mask, vq[i].cnt, vq[i].done,
                    vq[i].ovf, vq[i].cyc, vq[i].rd);
        end

        // Busy-cycle counter saturation.
        idle_inputs();
        clear = 1'b1;
        busy  = 1'b1;
        step();
        clear = 1'b0;
        chk("sat.start", 32'(cyc), 32'd0);
        for (int i = 1; i <= 70000; i++) begin
            step();
            if (i == 65534) chk("sat.65534", 32'(cyc), 32'h0000FFFE);
            if (i == 65535) chk("sat.65535", 32'(cyc), 32'h0000FFFF);
        end
        chk("sat.70000", 32'(cyc), 32'h0000FFFF);
        chk("sat.done", 32'(done), 32'd0);

        // Busy falls right after clear without a busy-high cycle seen in RUN.
        clear = 1'b1;
        step();
        clear = 1'b0;
        busy  = 1'b0;
        step();
        chk("nofall.done1", 32'(done), 32'd0);
        chk("nofall.cyc", 32'(cyc), 32'd0);
        step();
        chk("nofall.done2", 32'(done), 32'd0);
        chk("nofall.state", 32'(fsm_state), 32'd1);

        // Reset in the middle of an operation.
        busy = 1'b1; val = 1'b1; waddr = 8'd0; dout = 32'h1234;
        step();
        waddr = 8'd3; dout = 32'h5678;
        step();
        chk("mid.cnt", 32'(cnt), 32'd2);
        chk("mid.mask", 32'(mask), 32'h09);
        reset_i = 1'b1; waddr = 8'd4; dout = 32'hABCD;
        step();
        chk_all("midrst", 8'h00, 4'd0, 1'b0, 1'b0, 16'd0, 32'd0);
        chk("midrst.state", 32'(fsm_state), 32'd0);
        reset_i = 1'b0; busy = 1'b0; val = 1'b1; waddr = 8'd2; dout = 32'h77; rd_idx = 3'd0;
        step();
        chk_all("idle.strobe", 8'h00, 4'd0, 1'b0, 1'b0, 16'd0, 32'd0);
        val = 1'b0; rd_idx = 3'd3;
        step();
        chk("idle.rd3", rd_word, 32'd0);
        rd_idx = 3'd2;
        step();
        chk("idle.rd2", rd_word, 32'd0);
        chk("idle.state", 32'(fsm_state), 32'd0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("rearm.state", 32'(fsm_state), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
